// File: rtl/timer_pkg.sv
// Shared types and sizing helpers for the microsecond timer bank.
package timer_pkg;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} ch_state_t;

  localparam int DEFAULT_CNT_W = 16;

  // Width of a counter that holds 0..clock_mhz-1; never narrower than one bit.
  function automatic int presc_w(input int clock_mhz);
    return (clock_mhz < 2) ? 1 : $clog2(clock_mhz);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One programmable countdown channel: IDLE/RUN FSM, reloadable counter, expiry pulse.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             expire
);

  ch_state_t        r_state;
  ch_state_t        w_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_period;
  logic             r_periodic;
  logic             r_expire;
  logic             w_load_zero;
  logic             w_last;

  assign w_load_zero = (load_val == '0);
  // Final tick of a period: count sits at 1, so it never decrements to 0 in RUN.
  assign w_last      = (r_state == RUN) && tick && (r_count == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start)                     w_next = w_load_zero ? IDLE : RUN;
    else if (stop)                 w_next = IDLE;
    else if (w_last && !r_periodic) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_period   <= '0;
      r_periodic <= 1'b0;
      r_expire   <= 1'b0;
    end else begin
      r_expire <= 1'b0;
      if (start) begin
        if (w_load_zero) begin
          r_count  <= '0;
          r_expire <= 1'b1;
        end else begin
          r_count    <= load_val;
          r_period   <= load_val;
          r_periodic <= periodic;
        end
      end else if (!stop) begin
        if (w_last) begin
          r_expire <= 1'b1;
          r_count  <= r_periodic ? r_period : '0;
        end else if ((r_state == RUN) && tick) begin
          r_count <= r_count - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    running = (r_state == RUN);
    count   = r_count;
    expire  = r_expire;
  end

endmodule

// File: rtl/timer_bank.sv
// Shared 1 us prescaler feeding NUM_CH independent countdown channels.
module timer_bank
  import timer_pkg::*;
#(
  parameter int CLOCK_MHZ = 200,
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pause,
  input  logic [NUM_CH-1:0]       ch_start,
  input  logic [NUM_CH-1:0]       ch_stop,
  input  logic [NUM_CH-1:0]       ch_periodic,
  input  logic [NUM_CH*CNT_W-1:0] ch_load_val,
  output logic [NUM_CH*CNT_W-1:0] ch_count,
  output logic [NUM_CH-1:0]       ch_running,
  output logic [NUM_CH-1:0]       ch_expire,
  output logic                    usecond_pulse
);

  localparam int                 PRESC_W   = presc_w(CLOCK_MHZ);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLOCK_MHZ - 1);

  logic [PRESC_W-1:0] r_presc;
  logic               r_tick;
  logic               r_usec;

  // Prescaler: tick rises on the CLOCK_MHZ-th unpaused cycle; pause freezes the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_usec  <= 1'b0;
    end else begin
      r_usec <= r_tick;
      if (pause) begin
        r_tick <= 1'b0;
      end else if (r_presc == PRESC_MAX) begin
        r_presc <= '0;
        r_tick  <= 1'b1;
      end else begin
        r_presc <= r_presc + PRESC_W'(1);
        r_tick  <= 1'b0;
      end
    end
  end

  assign usecond_pulse = r_usec;

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      timer_channel #(.CNT_W(CNT_W)) u_ch (
        .clk      (clk),
        .rst      (rst),
        .tick     (r_tick),
        .start    (ch_start[g]),
        .stop     (ch_stop[g]),
        .periodic (ch_periodic[g]),
        .load_val (ch_load_val[g*CNT_W +: CNT_W]),
        .count    (ch_count[g*CNT_W +: CNT_W]),
        .running  (ch_running[g]),
        .expire   (ch_expire[g])
      );
    end
  endgenerate

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios plus a randomized run against a model.
module tb_timer_bank;

  localparam int TB_MHZ = 4;
  localparam int NCH    = 4;
  localparam int CW     = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           pause = 1'b0;
  logic [NCH-1:0] ch_start = '0;
  logic [NCH-1:0] ch_stop = '0;
  logic [NCH-1:0] ch_periodic = '0;
  logic [NCH*CW-1:0] ch_load_val = '0;
  logic [NCH*CW-1:0] ch_count;
  logic [NCH-1:0] ch_running;
  logic [NCH-1:0] ch_expire;
  logic           usecond_pulse;

  logic        w_start16 = 1'b0;
  logic        w_stop16 = 1'b0;
  logic        w_per16 = 1'b0;
  logic        w_pause16 = 1'b0;
  logic [15:0] w_load16 = '0;
  logic [15:0] count16;
  logic        run16;
  logic        exp16;
  logic        us16;

  int n_checks = 0;
  int n_fail   = 0;

  timer_bank #(.CLOCK_MHZ(TB_MHZ), .NUM_CH(NCH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .pause(pause),
    .ch_start(ch_start), .ch_stop(ch_stop), .ch_periodic(ch_periodic),
    .ch_load_val(ch_load_val), .ch_count(ch_count), .ch_running(ch_running),
    .ch_expire(ch_expire), .usecond_pulse(usecond_pulse)
  );

  timer_bank #(.CLOCK_MHZ(2), .NUM_CH(1), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .pause(w_pause16),
    .ch_start(w_start16), .ch_stop(w_stop16), .ch_periodic(w_per16),
    .ch_load_val(w_load16), .ch_count(count16), .ch_running(run16),
    .ch_expire(exp16), .usecond_pulse(us16)
  );

  always #5 clk = ~clk;

  // Reference model: tick every TB_MHZ-th unpaused cycle since reset, channels follow the rules directly.
  int       m_unp;
  logic     m_tick, m_us;
  logic [CW-1:0] m_cnt [NCH];
  logic [CW-1:0] m_prd [NCH];
  logic     m_run [NCH];
  logic     m_per [NCH];
  logic     m_exp [NCH];

  always @(posedge clk) begin
    if (rst) begin
      m_unp  <= 0;
      m_tick <= 1'b0;
      m_us   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        m_cnt[i] <= '0; m_prd[i] <= '0; m_run[i] <= 1'b0; m_per[i] <= 1'b0; m_exp[i] <= 1'b0;
      end
    end else begin
      m_us <= m_tick;
      if (!pause) begin
        m_unp  <= m_unp + 1;
        m_tick <= ((m_unp + 1) % TB_MHZ) == 0;
      end else begin
        m_tick <= 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
        m_exp[i] <= 1'b0;
        if (ch_start[i]) begin
          if (ch_load_val[i*CW +: CW] != 0) begin
            m_prd[i] <= ch_load_val[i*CW +: CW];
            m_cnt[i] <= ch_load_val[i*CW +: CW];
            m_per[i] <= ch_periodic[i];
            m_run[i] <= 1'b1;
          end else begin
            m_cnt[i] <= '0; m_run[i] <= 1'b0; m_exp[i] <= 1'b1;
          end
        end else if (ch_stop[i]) begin
          m_run[i] <= 1'b0;
        end else if (m_run[i] && m_tick) begin
          if (m_cnt[i] == 1) begin
            m_exp[i] <= 1'b1;
            if (m_per[i]) m_cnt[i] <= m_prd[i];
            else begin m_cnt[i] <= '0; m_run[i] <= 1'b0; end
          end else begin
            m_cnt[i] <= m_cnt[i] - 1;
          end
        end
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic exp_us;
    rst = 1'b1;
    repeat (3) cycle();
    n_checks++;
    if ({ch_count, ch_running, ch_expire, usecond_pulse} !== '0) begin
      n_fail++; $display("FAIL reset_state got %h required 0", {ch_count, ch_running, ch_expire, usecond_pulse});
    end
    rst = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      cycle();
      exp_us = (k >= 5) && (((k - 5) % TB_MHZ) == 0);
      n_checks++;
      if (usecond_pulse !== exp_us) begin
        n_fail++; $display("FAIL reset_usec cycle %0d got %b required %b", k, usecond_pulse, exp_us);
      end
      n_checks++;
      if ({ch_count, ch_running, ch_expire} !== '0) begin
        n_fail++; $display("FAIL idle_outputs cycle %0d got %h required 0", k, {ch_count, ch_running, ch_expire});
      end
    end
  endtask

  task automatic test_oneshot();
    int n = 0;
    bit done = 0;
    ch_load_val[7:0] = 8'd3; ch_periodic[0] = 1'b0; ch_start[0] = 1'b1;
    cycle();
    ch_start[0] = 1'b0;
    n_checks++;
    if (ch_count[7:0] !== 8'd3 || ch_running[0] !== 1'b1 || ch_expire[0] !== 1'b0) begin
      n_fail++; $display("FAIL oneshot_load cnt %0d run %b exp %b required 3 1 0", ch_count[7:0], ch_running[0], ch_expire[0]);
    end
    for (int c = 0; c < 40 && !done; c++) begin
      cycle();
      if (usecond_pulse) begin
        n++;
        n_checks++;
        if (n < 3) begin
          if (ch_count[7:0] !== 8'(3 - n) || ch_running[0] !== 1'b1 || ch_expire[0] !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_count tick %0d cnt %0d run %b exp %b required %0d 1 0", n, ch_count[7:0], ch_running[0], ch_expire[0], 3 - n);
          end
        end else begin
          done = 1;
          if (ch_count[7:0] !== 8'd0 || ch_running[0] !== 1'b0 || ch_expire[0] !== 1'b1) begin
            n_fail++; $display("FAIL oneshot_expire cnt %0d run %b exp %b required 0 0 1", ch_count[7:0], ch_running[0], ch_expire[0]);
          end
        end
      end else begin
        n_checks++;
        if (ch_expire[0] !== 1'b0) begin
          n_fail++; $display("FAIL oneshot_early_expire got 1 required 0 after %0d ticks", n);
        end
      end
    end
    if (!done) begin
      n_checks++; n_fail++; $display("FAIL oneshot_timeout saw %0d ticks required 3", n);
    end
    for (int c = 0; c < 20; c++) begin
      cycle();
      n_checks++;
      if (ch_expire[0] !== 1'b0 || ch_running[0] !== 1'b0) begin
        n_fail++; $display("FAIL oneshot_after exp %b run %b required 0 0", ch_expire[0], ch_running[0]);
      end
    end
  endtask

  task automatic test_periodic();
    int t = 0, last = 0, ne = 0, frozen;
    bit seen = 0;
    ch_load_val[15:8] = 8'd2; ch_periodic[1] = 1'b1; ch_start[1] = 1'b1;
    cycle();
    ch_start[1] = 1'b0; ch_periodic[1] = 1'b0;
    for (int c = 0; c < 80 && ne < 5; c++) begin
      cycle(); t++;
      if (ch_expire[1]) begin
        n_checks++;
        if (ch_count[15:8] !== 8'd2 || ch_running[1] !== 1'b1) begin
          n_fail++; $display("FAIL periodic_reload cnt %0d run %b required 2 1", ch_count[15:8], ch_running[1]);
        end
        if (ne > 0) begin
          n_checks++;
          if (t - last != 8) begin
            n_fail++; $display("FAIL periodic_interval got %0d cycles required 8", t - last);
          end
        end
        last = t; ne++;
      end
    end
    if (ne < 5) begin
      n_checks++; n_fail++; $display("FAIL periodic_timeout got %0d expiries required 5", ne);
    end
    pause = 1'b1;
    cycle(); t++;
    frozen = int'(ch_count[15:8]);
    for (int c = 0; c < 9; c++) begin
      cycle(); t++;
      n_checks++;
      if (int'(ch_count[15:8]) != frozen || ch_expire[1] !== 1'b0) begin
        n_fail++; $display("FAIL pause_frozen cnt %0d exp %b required %0d 0", ch_count[15:8], ch_expire[1], frozen);
      end
    end
    pause = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      cycle(); t++;
      if (ch_expire[1]) begin
        seen = 1;
        n_checks++;
        if (t - last != 18) begin
          n_fail++; $display("FAIL pause_delay got %0d cycles required 18", t - last);
        end
      end
    end
    if (!seen) begin
      n_checks++; n_fail++; $display("FAIL pause_timeout got no expiry required one");
    end
    ch_stop[1] = 1'b1;
    cycle();
    ch_stop[1] = 1'b0;
    n_checks++;
    if (ch_running[1] !== 1'b0) begin
      n_fail++; $display("FAIL periodic_stop run %b required 0", ch_running[1]);
    end
  endtask

  task automatic test_stop();
    int n = 0;
    ch_load_val[23:16] = 8'd5; ch_start[2] = 1'b1;
    cycle();
    ch_start[2] = 1'b0;
    for (int c = 0; c < 30 && n < 2; c++) begin
      cycle();
      if (usecond_pulse) n++;
    end
    n_checks++;
    if (n < 2 || ch_count[23:16] !== 8'd3) begin
      n_fail++; $display("FAIL stop_precount ticks %0d cnt %0d required 2 3", n, ch_count[23:16]);
    end
    ch_stop[2] = 1'b1;
    cycle();
    ch_stop[2] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if (ch_count[23:16] !== 8'd3 || ch_running[2] !== 1'b0 || ch_expire[2] !== 1'b0) begin
        n_fail++; $display("FAIL stop_hold cnt %0d run %b exp %b required 3 0 0", ch_count[23:16], ch_running[2], ch_expire[2]);
      end
      cycle();
    end
    ch_load_val[23:16] = 8'd4; ch_start[2] = 1'b1; ch_stop[2] = 1'b1;
    cycle();
    ch_start[2] = 1'b0; ch_stop[2] = 1'b0;
    n_checks++;
    if (ch_count[23:16] !== 8'd4 || ch_running[2] !== 1'b1) begin
      n_fail++; $display("FAIL start_beats_stop cnt %0d run %b required 4 1", ch_count[23:16], ch_running[2]);
    end
    ch_stop[2] = 1'b1;
    cycle();
    ch_stop[2] = 1'b0;
  endtask

  task automatic test_zero_restart();
    bit found = 0;
    ch_load_val[31:24] = 8'd0; ch_start[3] = 1'b1;
    cycle();
    ch_start[3] = 1'b0;
    n_checks++;
    if (ch_expire[3] !== 1'b1 || ch_running[3] !== 1'b0 || ch_count[31:24] !== 8'd0) begin
      n_fail++; $display("FAIL zero_load exp %b run %b cnt %0d required 1 0 0", ch_expire[3], ch_running[3], ch_count[31:24]);
    end
    cycle();
    n_checks++;
    if (ch_expire[3] !== 1'b0) begin
      n_fail++; $display("FAIL zero_load_pulse_width exp %b required 0", ch_expire[3]);
    end
    ch_load_val[7:0] = 8'd5; ch_start[0] = 1'b1;
    cycle();
    ch_start[0] = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      cycle();
      if (ch_count[7:0] == 8'd2) found = 1;
    end
    ch_load_val[7:0] = 8'd6; ch_start[0] = 1'b1;
    cycle();
    ch_start[0] = 1'b0;
    n_checks++;
    if (!found || ch_count[7:0] !== 8'd6 || ch_expire[0] !== 1'b0 || ch_running[0] !== 1'b1) begin
      n_fail++; $display("FAIL restart found %b cnt %0d exp %b run %b required 1 6 0 1", found, ch_count[7:0], ch_expire[0], ch_running[0]);
    end
    ch_stop[0] = 1'b1;
    cycle();
    ch_stop[0] = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    ch_load_val = {8'd5, 8'd4, 8'd3, 8'd1};
    ch_periodic = 4'hF; ch_start = 4'hF;
    cycle();
    ch_start = '0; ch_periodic = '0;
    for (int c = 0; c < 20 && !found; c++) begin
      cycle();
      if (usecond_pulse) found = 1;
    end
    repeat (3) cycle();
    n_checks++;
    if (!found || ch_running !== 4'hF || ch_count[7:0] !== 8'd1) begin
      n_fail++; $display("FAIL reset_mid_setup found %b run %b cnt0 %0d required 1 f 1", found, ch_running, ch_count[7:0]);
    end
    rst = 1'b1;
    cycle();
    n_checks++;
    if ({ch_count, ch_running, ch_expire, usecond_pulse} !== '0) begin
      n_fail++; $display("FAIL reset_mid got %h required 0", {ch_count, ch_running, ch_expire, usecond_pulse});
    end
    cycle();
    n_checks++;
    if (ch_expire !== '0) begin
      n_fail++; $display("FAIL reset_mid_expire got %b required 0", ch_expire);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [NCH*CW-1:0] e_cnt;
    logic [NCH-1:0]    e_run, e_exp;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NCH; i++) begin
        ch_start[i] = ($urandom_range(0, 7) == 0);
        ch_stop[i] = ($urandom_range(0, 9) == 0);
        ch_periodic[i] = 1'($urandom_range(0, 1));
        ch_load_val[i*CW +: CW] = 8'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 15) == 0) pause = ~pause;
      cycle();
      for (int i = 0; i < NCH; i++) begin
        e_cnt[i*CW +: CW] = m_cnt[i];
        e_run[i] = m_run[i];
        e_exp[i] = m_exp[i];
      end
      n_checks++;
      if (usecond_pulse !== m_us) begin
        n_fail++; $display("FAIL rand_usec cycle %0d got %b required %b", c, usecond_pulse, m_us);
      end
      n_checks++;
      if (ch_count !== e_cnt) begin
        n_fail++; $display("FAIL rand_count cycle %0d got %h required %h", c, ch_count, e_cnt);
      end
      n_checks++;
      if (ch_running !== e_run) begin
        n_fail++; $display("FAIL rand_running cycle %0d got %b required %b", c, ch_running, e_run);
      end
      n_checks++;
      if (ch_expire !== e_exp) begin
        n_fail++; $display("FAIL rand_expire cycle %0d got %b required %b", c, ch_expire, e_exp);
      end
    end
    ch_start = '0; ch_stop = '0; ch_periodic = '0; pause = 1'b0;
    cycle();
  endtask

  task automatic test_wide();
    int  n = 0;
    bit  seen = 0;
    w_load16 = 16'hFFFF; w_start16 = 1'b1;
    cycle();
    w_start16 = 1'b0;
    n_checks++;
    if (count16 !== 16'hFFFF || run16 !== 1'b1) begin
      n_fail++; $display("FAIL wide_load cnt %0d run %b required 65535 1", count16, run16);
    end
    for (int c = 0; c < 600; c++) begin
      cycle();
      if (us16) n++;
      if (exp16) seen = 1;
    end
    n_checks++;
    if (count16 !== 16'(65535 - n) || run16 !== 1'b1 || seen) begin
      n_fail++; $display("FAIL wide_count cnt %0d run %b exp_seen %b required %0d 1 0", count16, run16, seen, 65535 - n);
    end
    w_load16 = 16'd2; w_start16 = 1'b1;
    cycle();
    w_start16 = 1'b0;
    n = 0; seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cycle();
      if (us16) n++;
      if (exp16) seen = 1;
    end
    n_checks++;
    if (!seen || n != 2 || run16 !== 1'b0) begin
      n_fail++; $display("FAIL wide_expire seen %b ticks %0d run %b required 1 2 0", seen, n, run16);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_stop();
    test_zero_restart();
    test_reset_mid();
    test_random();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised successor to the free-running µs/ms timer.
- One shared microsecond prescaler drives NUM_CH independent, programmable countdown channels.
- Each channel runs in one-shot or periodic mode and emits a single-cycle expire pulse.
- Sits beside the render controller for frame pacing, watchdogs and benchmark intervals; software-style start/stop strobes come from the control block.

Parameters:
- CLOCK_MHZ, 200: clk frequency in MHz; prescaler divides by this to form the 1 µs tick; legal 2..255.
- NUM_CH, 4: number of countdown channels; legal 1..16.
- CNT_W, 16: channel counter width in µs ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- pause  in  1  freezes prescaler, so all channels hold; commands still accepted.
- ch_start  in  NUM_CH  per-channel start/restart strobe.
- ch_stop  in  NUM_CH  per-channel stop strobe.
- ch_periodic  in  NUM_CH  mode sampled at start: 1 periodic, 0 one-shot.
- ch_load_val  in  NUM_CH*CNT_W  period in µs; channel i uses bits [i*CNT_W +: CNT_W].
- ch_count  out  NUM_CH*CNT_W  current remaining count, same packing.
- ch_running  out  NUM_CH  1 while channel is in RUN.
- ch_expire  out  NUM_CH  one-cycle expiry pulse.
- usecond_pulse  out  1  registered copy of the µs tick.

Behaviour:
- Reset: prescaler=0, tick=0; every channel IDLE, count=0, period=0, periodic=0, running=0, expire=0; usecond_pulse=0. Reset overrides all inputs.
- Prescaler:
  - counter 0..CLOCK_MHZ-1; registered tick is high for exactly one cycle in every CLOCK_MHZ unpaused cycles.
  - First tick comes CLOCK_MHZ cycles after rst deasserts.
  - pause=1 holds counter and tick (no tick while paused).
  - usecond_pulse = tick delayed one cycle.
- Channel FSM, states IDLE and RUN:
  - ch_start[i] (any state), load_val!=0:
    - latch period=load_val and periodic=ch_periodic[i]; count<=load_val; RUN. Takes effect next cycle.
    - A tick in the same cycle is ignored.
  - ch_start[i] with load_val==0: count<=0; IDLE; ch_expire[i]=1 next cycle (immediate expiry, no reload).
  - ch_stop[i] in RUN: IDLE; count holds its value; no expire. Stop while IDLE has no effect.
  - Simultaneous start and stop: start wins.
  - RUN and tick and count>1: count<=count-1.
  - RUN and tick and count==1:
    - ch_expire[i]=1 for the following cycle.
    - periodic: count<=period, stays RUN, so expiries are exactly period µs apart.
    - one-shot: count<=0, IDLE.
  - ch_expire is registered; it is high only in the cycle after the expiring tick/start.
  - ch_running is the registered state (RUN=1).
- Arithmetic: unsigned CNT_W; count never decrements below 1 in RUN, so no wrap. Maximum period is 2^CNT_W-1 µs.
- Channels are fully independent and share only the tick; all may expire in the same cycle.
- Reset mid-run: all channels IDLE, no expire pulse generated.

Decomposition:
- Package timer_pkg:
  - channel state enum {IDLE, RUN};
  - localparam PRESC_W = $clog2(CLOCK_MHZ) helper function;
  - default CNT_W constant.
- Sub-module timer_channel: one channel FSM plus counter, parametrised by CNT_W, inputs tick/start/stop/periodic/load_val. Instantiated NUM_CH times by generate.
- Prescaler stays in timer_bank top.

Test Plan (CLOCK_MHZ=4, NUM_CH=4, CNT_W=8 unless noted):
- Release rst, idle -> usecond_pulse high once every 4 cycles, first at cycle 5 after reset release; all ch_* outputs 0.
- ch0 one-shot, load 3 -> ch_count 3,2,1 on successive ticks; ch_expire[0] high 1 cycle at the 3rd tick+1; running then 0, count 0; no further pulses.
- ch1 periodic, load 2 -> ch_expire[1] every 8 clk cycles for 5 periods; count reloads to 2 each time. Assert pause for 10 cycles -> count frozen, expiry delayed by exactly 10 cycles.
- ch2 started with load 5; stop after 2 ticks -> count holds 3, running 0, no expire. Start+stop same cycle with load 4 -> RUN, count 4.
- ch3 start with load 0 -> ch_expire[3] next cycle, running 0. Restart ch0 (load 6) at count 2 -> count 6, no expire.
- rst asserted while channels 0-3 are running, with one due to expire that cycle -> all outputs 0 next cycle, no expire pulse. CNT_W=16, load 65535 one-shot -> expiry after 65535 ticks.
